// File: rtl/iter_shifter_pkg.sv
// Shared encodings for the shift/rotate units and decode logic.
package iter_shifter_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iter_shifter_step.sv
// One iteration of the shifter: shift or rotate by 1 or 2 positions.
module shift_step
  import iter_shifter_pkg::*;
(
  input  logic [DATA_W-1:0] Data,
  input  logic [OP_W-1:0]   Op,
  input  logic              By2,
  output logic [DATA_W-1:0] Out
);

  always_comb begin
    Out = Data;
    case (op_e'(Op))
      OP_ROL:  Out = By2 ? {Data[13:0], Data[15:14]} : {Data[14:0], Data[15]};
      OP_SLL:  Out = By2 ? {Data[13:0], 2'b00}       : {Data[14:0], 1'b0};
      OP_ROR:  Out = By2 ? {Data[1:0], Data[15:2]}   : {Data[0], Data[15:1]};
      OP_SRL:  Out = By2 ? {2'b00, Data[15:2]}       : {1'b0, Data[15:1]};
      default: Out = Data;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle 16-bit shift/rotate unit retiring up to 2 bit positions per cycle,
// with valid/ready handshakes on input and output.
module iter_shifter
  import iter_shifter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] In,
  input  logic [CNT_W-1:0]  Cnt,
  input  logic [OP_W-1:0]   Op,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] Out,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] step_out;

  shift_step u_step (
    .Data (data_q),
    .Op   (op_q),
    .By2  (rem_q >= CNT_W'(2)),
    .Out  (step_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = In;
          rem_d   = Cnt;
          op_d    = Op;
          state_d = (Cnt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = step_out;
        rem_d  = (rem_q >= CNT_W'(2)) ? rem_q - CNT_W'(2) : '0;
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags follow the next state so they are plain flop outputs.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      rem_q       <= '0;
      op_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Out       = data_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Randomized self-checking bench for iter_shifter against a behavioural shift model.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] In;
  logic [3:0]  Cnt;
  logic [1:0]  Op;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Out;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  iter_shifter dut (
    .clk       (clk),
    .rst       (rst),
    .In        (In),
    .Cnt       (Cnt),
    .Op        (Op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Out       (Out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Rotates via a doubled word; logical shifts via plain operators.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int c, input logic [1:0] op);
    logic [31:0] w;
    w = {d, d};
    case (op)
      2'b00: begin w = w << c; return w[31:16]; end
      2'b01: return 16'(d << c);
      2'b10: begin w = w >> c; return w[15:0]; end
      default: return 16'(d >> c);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, track latency, hold the result for `hold` cycles, then take it.
  task automatic run_op(input logic [15:0] din, input logic [3:0] cnt, input logic [1:0] op,
                        input int hold);
    logic [15:0] exp;
    int k;
    exp = ref_shift(din, int'(cnt), op);
    check("in_ready_before_accept", 32'(in_ready), 32'(1));
    In = din; Cnt = cnt; Op = op; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    k = 1;
    while (!out_valid && k < 40) begin
      check("in_ready_during_shift", 32'(in_ready), 32'(0));
      in_valid = 1'($urandom_range(0, 1));
      In = 16'($urandom); Cnt = 4'($urandom); Op = 2'($urandom);
      tick();
      k++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 32'(out_valid), 32'(1));
      return;
    end
    check("latency", 32'(k), 32'(1 + (int'(cnt) + 1) / 2));
    check("result", 32'(Out), 32'(exp));
    check("in_ready_in_done", 32'(in_ready), 32'(0));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      In = 16'($urandom); Cnt = 4'($urandom); Op = 2'($urandom);
      tick();
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_result", 32'(Out), 32'(exp));
      check("hold_in_ready", 32'(in_ready), 32'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("valid_drop_after_take", 32'(out_valid), 32'(0));
    check("in_ready_after_take", 32'(in_ready), 32'(1));
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; In = '0; Cnt = '0; Op = '0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'(1));
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_out", 32'(Out), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_op(16'h8001, 4'd4, 2'b00, 0);
    check("rol_example", 32'(ref_shift(16'h8001, 4, 2'b00)), 32'h0018);
    run_op(16'hFFFF, 4'd15, 2'b01, 0);
    run_op(16'h0001, 4'd1, 2'b10, 0);
    run_op(16'h8000, 4'd0, 2'b11, 0);
    run_op(16'h00F0, 4'd3, 2'b11, 3);

    // Abort an operation in flight with an asynchronous reset.
    In = 16'h1234; Cnt = 4'd10; Op = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_in_ready", 32'(in_ready), 32'(1));
    check("abort_out", 32'(Out), 32'(0));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", 32'(out_valid), 32'(0));
    end
    run_op(16'h0003, 4'd2, 2'b01, 0);

    for (int i = 0; i < 60; i++)
      run_op(16'($urandom), 4'($urandom), 2'($urandom), int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
